video_tpg: RTL and testbench
============================

VIDEO_TPG -- requirements
Module: video_tpg

Interface
REQ-001 SHALL have parameter H_WIDTH, default 1920, active pixels per line.
REQ-002 SHALL have parameter H_START, default 2008, first hsync pixel.
REQ-003 SHALL have parameter H_SYNC, default 44, hsync width in pixels.
REQ-004 SHALL have parameter H_TOTAL, default 2200, pixels per line.
REQ-005 SHALL have parameter V_HEIGHT, default 1080, active lines.
REQ-006 SHALL have parameter V_START, default 1084, first vsync line.
REQ-007 SHALL have parameter V_SYNC, default 5, vsync width in lines.
REQ-008 SHALL have parameter V_TOTAL, default 1125, lines per frame.
REQ-009 SHALL have parameters KH and KV, default 30 each, checker tile width and height.
REQ-010 SHALL have port clk_i, input, 1, pixel clock; the block uses one clock only.
REQ-011 SHALL have port rst_i, input, 1, reset; asynchronous, active-high.
REQ-012 SHALL have port en_i, input, 1, generator enable.
REQ-013 SHALL have port pattern_i, input, 2, pattern select: 0 solid, 1 bars, 2 gradient, 3 checker.
REQ-014 SHALL have port color_i, input, 24, solid colour {R,G,B}.
REQ-015 SHALL have ports vout_hs_o, vout_vs_o and vout_de_o, output, 1 each, sync and data enable.
REQ-016 SHALL have port vout_data_o, output, 24, pixel {R[23:16],G[15:8],B[7:0]}.
REQ-017 SHALL have port frame_start_o, output, 1, one-cycle pulse at first pixel of frame.
REQ-018 SHALL have port frame_cnt_o, output, 16, completed-frame count.

Function
REQ-019 SHALL keep h counter 0..H_TOTAL-1 and v counter 0..V_TOTAL-1.
- h wraps to 0 after H_TOTAL-1 and increments v.
- v wraps to 0 after V_TOTAL-1 at h wrap.
REQ-020 SHALL register every output, with one cycle latency from counter state (h,v) to outputs.
REQ-021 SHALL drive vout_de_o=1 iff h<H_WIDTH and v<V_HEIGHT.
REQ-022 SHALL drive vout_hs_o=1 iff H_START<=h<H_START+H_SYNC, positive polarity, on every line including blanking lines.
REQ-023 SHALL drive vout_vs_o=1 iff V_START<=v<V_START+V_SYNC, for whole lines, positive polarity.
REQ-024 SHALL drive vout_data_o=0 whenever vout_de_o=0.
REQ-025 SHALL sample pattern_i and color_i only when (h,v)=(0,0), holding them for the whole frame; mid-frame changes take effect next frame.
REQ-026 SHALL output color_i for pattern 0.
REQ-027 SHALL output eight equal bars of H_WIDTH/8 pixels for pattern 1, in order white, yellow, cyan, green, magenta, red, blue, black (components 0xFF/0x00).
- Bar index comes from a counter, not division.
- H_WIDTH is required divisible by 8.
REQ-028 SHALL output R=G=B=h[7:0] for pattern 2.
REQ-029 SHALL output a checker for pattern 3.
- tx=h/KH and ty=v/KV come from tile counters, not division.
- Pixel is 0xFFFFFF when tx[0]^ty[0]=0, else 0x000000.
- Partial edge tiles are allowed.
REQ-030 SHALL pulse frame_start_o for exactly one cycle, aligned with the output pixel for (0,0).
REQ-031 SHALL increment frame_cnt_o by 1 when v and h both wrap, with 0xFFFF wrapping to 0x0000.
REQ-032 SHALL, when en_i=0, at next edge set counters to (0,0) and all outputs except frame_cnt_o to 0; frame_cnt_o holds.
REQ-033 SHALL, when en_i returns to 1, start at (0,0): first output pixel (0,0) appears one cycle later with frame_start_o=1.

Reset
REQ-034 SHALL, while rst_i=1, immediately force counters, latched pattern/colour, frame_cnt_o and all outputs to 0, regardless of clock.
REQ-035 SHALL, after rst_i deasserts with en_i=1, output pixel (0,0) on the second rising edge; a reset mid-frame restarts at (0,0).

Verification
(Bench params: H_WIDTH=16, H_START=18, H_SYNC=2, H_TOTAL=22, V_HEIGHT=4, V_START=5, V_SYNC=1, V_TOTAL=7, KH=4, KV=2.)
REQ-036 SHALL verify timing: en_i=1 for 2 frames -> per line 16 de cycles, hs high at h=18,19 only; vs high for line 5 only (22 cycles); frame_start_o period 154.
REQ-037 SHALL verify bars: pattern_i=1 -> each line gives 2 px each of FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
REQ-038 SHALL verify checker: pattern_i=3 -> line 0 gives FFFFFF x4, 000000 x4 repeating; line 2 starts 000000 x4.
REQ-039 SHALL verify mid-frame change: switch pattern_i 0->2 at v=1 with color_i=123456 -> rest of frame 123456; next frame gradient 00..0F per line.
REQ-040 SHALL verify reset and enable:
- rst_i pulse at v=2,h=7 -> all outputs 0 asynchronously; restart at (0,0); frame_cnt_o=0.
- en_i low for 10 cycles -> outputs 0; frame_cnt_o held.
REQ-041 SHALL verify counter wrap: preload frame_cnt_o=0xFFFF via force -> after next frame end reads 0x0000.

Source files
------------

// File: rtl/video_tpg.sv
// Purpose: video timing + test pattern generator (solid, colour bars, gradient, checker).
// Latency: one cycle from counter state (h,v) to every registered output.
// Backpressure: none; free-running while en_i=1, parked at (0,0) with outputs low when en_i=0.
module video_tpg #(
    parameter int H_WIDTH  = 1920,
    parameter int H_START  = 2008,
    parameter int H_SYNC   = 44,
    parameter int H_TOTAL  = 2200,
    parameter int V_HEIGHT = 1080,
    parameter int V_START  = 1084,
    parameter int V_SYNC   = 5,
    parameter int V_TOTAL  = 1125,
    parameter int KH       = 30,
    parameter int KV       = 30
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [1:0]  pattern_i,
    input  logic [23:0] color_i,
    output logic        vout_hs_o,
    output logic        vout_vs_o,
    output logic        vout_de_o,
    output logic [23:0] vout_data_o,
    output logic        frame_start_o,
    output logic [15:0] frame_cnt_o
);

    localparam int HW    = $clog2(H_TOTAL);
    localparam int VW    = $clog2(V_TOTAL);
    localparam int BAR_W = H_WIDTH / 8;

    // run stays low for the first enabled cycle after reset so pixel (0,0)
    // emerges on the second rising edge after reset release.
    logic          run;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [15:0]   tile_hx;
    logic [15:0]   tile_vy;
    logic          tx;
    logic          ty;
    logic [15:0]   bar_px;
    logic [2:0]    bar_idx;
    logic [1:0]    pat_q;
    logic [23:0]   col_q;

    logic          adv;
    logic          h_last;
    logic          v_last;
    logic          at_origin;
    logic [1:0]    pat_cur;
    logic [23:0]   col_cur;
    logic          de_n;
    logic          hs_n;
    logic          vs_n;
    logic [7:0]    grad;
    logic [23:0]   pix;

    // Decode the current counter position; at (0,0) the live inputs are used
    // directly so the first pixel of a frame already reflects the new selection.
    always_comb begin
        adv       = en_i & run;
        h_last    = (32'(h) == H_TOTAL - 1);
        v_last    = (32'(v) == V_TOTAL - 1);
        at_origin = (h == '0) && (v == '0);
        pat_cur   = at_origin ? pattern_i : pat_q;
        col_cur   = at_origin ? color_i : col_q;
        de_n      = (32'(h) < H_WIDTH) && (32'(v) < V_HEIGHT);
        hs_n      = (32'(h) >= H_START) && (32'(h) < H_START + H_SYNC);
        vs_n      = (32'(v) >= V_START) && (32'(v) < V_START + V_SYNC);
        grad      = 8'(h);
        case (pat_cur)
            2'd0:    pix = col_cur;
            // Bar colour bits: R off for odd pairs, G off for the second half, B off for odd bars.
            2'd1:    pix = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
            2'd2:    pix = {grad, grad, grad};
            default: pix = (tx ^ ty) ? 24'h000000 : 24'hFFFFFF;
        endcase
        if (!de_n) begin
            pix = 24'h000000;
        end
    end

    // Raster, tile and bar counters; parked at (0,0) while disabled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run     <= 1'b0;
            h       <= '0;
            v       <= '0;
            tile_hx <= '0;
            tile_vy <= '0;
            tx      <= 1'b0;
            ty      <= 1'b0;
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (!en_i) begin
            h       <= '0;
            v       <= '0;
            tile_hx <= '0;
            tile_vy <= '0;
            tx      <= 1'b0;
            ty      <= 1'b0;
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (!run) begin
            run <= 1'b1;
        end else if (h_last) begin
            h       <= '0;
            tile_hx <= '0;
            tx      <= 1'b0;
            bar_px  <= '0;
            bar_idx <= '0;
            if (v_last) begin
                v       <= '0;
                tile_vy <= '0;
                ty      <= 1'b0;
            end else begin
                v <= v + 1'b1;
                if (tile_vy == 16'(KV - 1)) begin
                    tile_vy <= '0;
                    ty      <= ~ty;
                end else begin
                    tile_vy <= tile_vy + 1'b1;
                end
            end
        end else begin
            h <= h + 1'b1;
            if (tile_hx == 16'(KH - 1)) begin
                tile_hx <= '0;
                tx      <= ~tx;
            end else begin
                tile_hx <= tile_hx + 1'b1;
            end
            if (bar_px == 16'(BAR_W - 1)) begin
                bar_px  <= '0;
                bar_idx <= bar_idx + 1'b1;
            end else begin
                bar_px <= bar_px + 1'b1;
            end
        end
    end

    // Latch pattern and colour once per frame at the origin pixel.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pat_q <= '0;
            col_q <= '0;
        end else if (adv && at_origin) begin
            pat_q <= pattern_i;
            col_q <= color_i;
        end
    end

    // Registered video outputs and completed-frame counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vout_hs_o     <= 1'b0;
            vout_vs_o     <= 1'b0;
            vout_de_o     <= 1'b0;
            vout_data_o   <= '0;
            frame_start_o <= 1'b0;
            frame_cnt_o   <= '0;
        end else if (!adv) begin
            vout_hs_o     <= 1'b0;
            vout_vs_o     <= 1'b0;
            vout_de_o     <= 1'b0;
            vout_data_o   <= '0;
            frame_start_o <= 1'b0;
        end else begin
            vout_hs_o     <= hs_n;
            vout_vs_o     <= vs_n;
            vout_de_o     <= de_n;
            vout_data_o   <= pix;
            frame_start_o <= at_origin;
            if (h_last && v_last) begin
                frame_cnt_o <= frame_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_video_tpg.sv
// Purpose: directed self-checking bench for video_tpg with a tiny 22x7 raster.
// Latency: expects each pixel one cycle after its counter state, (0,0) two edges after reset release.
// Backpressure: none; enable and reset are exercised directly.
module tb_video_tpg;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  pattern;
    logic [23:0] color;
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] data;
    logic        fs;
    logic [15:0] fcnt;

    int          total  = 0;
    int          passed = 0;
    int          fails  = 0;
    int          mh     = 0;
    int          mv     = 0;
    logic [1:0]  exp_pat = 2'd0;
    logic [23:0] exp_col = 24'h0;
    logic [15:0] exp_cnt = 16'h0;

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    video_tpg #(
        .H_WIDTH(16), .H_START(18), .H_SYNC(2), .H_TOTAL(22),
        .V_HEIGHT(4), .V_START(5), .V_SYNC(1), .V_TOTAL(7),
        .KH(4), .KV(2)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .pattern_i(pattern), .color_i(color),
        .vout_hs_o(hs), .vout_vs_o(vs), .vout_de_o(de), .vout_data_o(data),
        .frame_start_o(fs), .frame_cnt_o(fcnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] outs();
        return {20'h0, hs, vs, de, fs, data, fcnt};
    endfunction

    function automatic logic [23:0] exp_pix(int x, int y, logic [1:0] p, logic [23:0] c);
        if (!(x < 16 && y < 4)) return 24'h0;
        case (p)
            2'd0:    return c;
            2'd1:    return bars[x / 2];
            2'd2:    return {8'(x), 8'(x), 8'(x)};
            default: return ((((x / 4) + (y / 2)) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
        endcase
    endfunction

    // One active pixel: compare every output against the model for (mh,mv).
    task automatic step();
        logic ehs, evs, ede, efs;
        @(posedge clk);
        #1;
        if (mh == 0 && mv == 0) begin
            exp_pat = pattern;
            exp_col = color;
        end
        if (mh == 21 && mv == 6) exp_cnt = exp_cnt + 16'd1;
        ehs = (mh == 18 || mh == 19);
        evs = (mv == 5);
        ede = (mh < 16 && mv < 4);
        efs = (mh == 0 && mv == 0);
        chk($sformatf("pix(%0d,%0d)", mh, mv), outs(),
            {20'h0, ehs, evs, ede, efs, exp_pix(mh, mv, exp_pat, exp_col), exp_cnt});
        if (mh == 21) begin
            mh = 0;
            mv = (mv == 6) ? 0 : mv + 1;
        end else begin
            mh = mh + 1;
        end
    endtask

    // One cycle where every output except the frame counter must be low.
    task automatic zero_step(input string tag);
        @(posedge clk);
        #1;
        chk(tag, outs(), {48'h0, exp_cnt});
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; pattern = 2'd0; color = 24'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", outs(), 64'h0);

        // Release with enable: one idle edge, then pixel (0,0).
        pattern = 2'd0; color = 24'hABCDEF; en = 1'b1; rst = 1'b0;
        zero_step("post_reset_gap");
        repeat (308) step();
        chk("cnt_after_2_frames", {48'h0, fcnt}, 64'd2);

        pattern = 2'd1;
        repeat (154) step();

        pattern = 2'd3;
        repeat (154) step();

        // Mid-frame change: takes effect only at the next frame.
        pattern = 2'd0; color = 24'h123456;
        repeat (24) step();
        pattern = 2'd2; color = 24'h000000;
        repeat (130) step();
        repeat (154) step();
        chk("cnt_after_6_frames", {48'h0, fcnt}, 64'd6);

        // Asynchronous reset at (7,2).
        pattern = 2'd3;
        repeat (51) step();
        rst = 1'b1;
        #2;
        chk("async_reset", outs(), 64'h0);
        exp_cnt = 16'h0;
        zero_step("reset_held");
        rst = 1'b0;
        zero_step("post_reset_gap2");
        mh = 0; mv = 0;
        repeat (154) step();

        // Enable low for 10 cycles, frame counter holds.
        repeat (30) step();
        en = 1'b0;
        repeat (10) zero_step("disabled");
        en = 1'b1;
        mh = 0; mv = 0;
        repeat (154) step();
        chk("cnt_after_enable", {48'h0, fcnt}, 64'd2);

        // Frame counter wrap from 0xFFFF.
        repeat (40) step();
        force dut.frame_cnt_o = 16'hFFFF;
        #1;
        release dut.frame_cnt_o;
        exp_cnt = 16'hFFFF;
        chk("cnt_preload", {48'h0, fcnt}, 64'hFFFF);
        repeat (114) step();
        chk("cnt_wrap", {48'h0, fcnt}, 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
